// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
// Consumed by the interface, the controller and the bench.
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between control logic and the serial adder.
// No latency of its own; carries start/operands in and busy/done/result out.
// No backpressure: start is only honoured while the adder is idle.
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/halfadder.sv
// Single-bit half adder, the lab's basic datapath cell.
// Purely combinational, zero cycles.
// No flow control.
module halfadder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// Full-adder bit cell built from two half adders and an OR.
// Purely combinational, zero cycles.
// No flow control.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (.x(x),  .y(y),   .s(s0), .c(c0));
    halfadder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder time-sharing one full-adder cell, LSB first.
// Latency: done pulses WIDTH cycles after the accepting edge; next accept at +WIDTH+2.
// No queuing: start is ignored while busy; hold it high to re-issue on return to idle.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           st;
    state_t           nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic bit_s;
    logic bit_c;
    logic last;
    logic load;
    logic step;
    logic busy_d;
    logic done_d;

    full_adder_bit u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .cin(carry),
        .s  (bit_s),
        .co (bit_c)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ST_IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            ST_IDLE: if (bus.start) nxt = ST_RUN;
            ST_RUN:  if (last) nxt = ST_DONE;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath strobes.
    always_comb begin
        load   = (st == ST_IDLE) && bus.start;
        step   = (st == ST_RUN);
        done_d = step && last;
        busy_d = (nxt == ST_RUN) || (nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (load) begin
                sh_a  <= bus.a;
                sh_b  <= bus.b;
                res   <= '0;
                cnt   <= '0;
                carry <= 1'b0;
            end else if (step) begin
                sh_a  <= sh_a >> 1;
                sh_b  <= sh_b >> 1;
                res   <= {bit_s, res[WIDTH-1:1]};
                cnt   <= cnt + 1'b1;
                carry <= bit_c;
            end
            // Result is published only on the final bit so partial sums never leak.
            if (done_d) begin
                sum_q  <= {bit_s, res[WIDTH-1:1]};
                cout_q <= bit_c;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
// Stimulus pushes expected results; per-instance monitors pop on done.
module tb_serial_add_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q8[$];
    exp_t q2[$];
    int   last_acc8;

    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(2)) if2 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_add_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: compare on done, then confirm the result holds once done drops.
    logic       held8 = 1'b0;
    logic [7:0] hs8;
    logic       hc8;
    always @(negedge clk) begin
        if (held8) begin
            held8 = 1'b0;
            if (rst_n) begin
                chk("hold_done8", 32'(if8.done), 32'(0));
                chk("hold_sum8", 32'(if8.sum), 32'(hs8));
                chk("hold_cout8", 32'(if8.cout), 32'(hc8));
            end
        end
        if (rst_n && if8.done) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sum8", 32'(if8.sum), 32'(e.sum));
                chk("cout8", 32'(if8.cout), 32'(e.cout));
                chk("latency8", 32'(cyc), 32'(e.acc + 8));
                held8 = 1'b1;
                hs8   = e.sum;
                hc8   = e.cout;
            end
        end
    end

    logic       held2 = 1'b0;
    logic [1:0] hs2;
    logic       hc2;
    always @(negedge clk) begin
        if (held2) begin
            held2 = 1'b0;
            if (rst_n) begin
                chk("hold_sum2", 32'(if2.sum), 32'(hs2));
                chk("hold_cout2", 32'(if2.cout), 32'(hc2));
            end
        end
        if (rst_n && if2.done) begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("sum2", 32'(if2.sum), 32'(e.sum));
                chk("cout2", 32'(if2.cout), 32'(e.cout));
                chk("latency2", 32'(cyc), 32'(e.acc + 2));
                held2 = 1'b1;
                hs2   = e.sum[1:0];
                hc2   = e.cout;
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec);
        @(negedge clk);
        if8.a     = a;
        if8.b     = b;
        if8.start = 1'b1;
        last_acc8 = cyc + 1;
        q8.push_back('{sum: es, cout: ec, acc: cyc + 1});
        @(negedge clk);
        if8.start = 1'b0;
        chk("busy_after_accept8", 32'(if8.busy), 32'(1));
    endtask

    task automatic idle8();
        int n;
        n = 0;
        while (if8.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("timeout8", 32'(0), 32'(1));
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] t;
        t = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        if2.a     = a;
        if2.b     = b;
        if2.start = 1'b1;
        q2.push_back('{sum: {6'd0, t[1:0]}, cout: t[2], acc: cyc + 1});
        @(negedge clk);
        if2.start = 1'b0;
        chk("busy_after_accept2", 32'(if2.busy), 32'(1));
        for (int n = 0; n < 20 && if2.busy; n++) @(negedge clk);
        if (if2.busy) chk("timeout2", 32'(0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        int   acc0;
        rst_n     = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(if8.busy), 32'(0));
        chk("rst_done", 32'(if8.done), 32'(0));
        chk("rst_sum", 32'(if8.sum), 32'(0));
        chk("rst_cout", 32'(if8.cout), 32'(0));
        chk("rst_busy2", 32'(if2.busy), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic adds and carry-out boundaries.
        op8(8'h05, 8'h03, 8'h08, 1'b0); idle8();
        op8(8'hFF, 8'h01, 8'h00, 1'b1); idle8();
        op8(8'hFF, 8'hFF, 8'hFE, 1'b1); idle8();
        op8(8'h00, 8'h00, 8'h00, 1'b0); idle8();

        // Starts during RUN and DONE are ignored; operand changes mid-run have no effect.
        op8(8'h12, 8'h34, 8'h46, 1'b0);
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h99; if8.b = 8'h77;
        repeat (2) @(negedge clk);
        if8.start = 1'b0;
        while (cyc < last_acc8 + 8) @(negedge clk);
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        idle8();

        // Asynchronous reset mid-operation, between clock edges.
        op8(8'hAA, 8'h55, 8'hFF, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        q8.delete();
        #1;
        chk("arst_busy", 32'(if8.busy), 32'(0));
        chk("arst_done", 32'(if8.done), 32'(0));
        chk("arst_sum", 32'(if8.sum), 32'(0));
        chk("arst_cout", 32'(if8.cout), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) saw_done = 1'b1;
        end
        chk("no_done_after_reset", 32'(saw_done), 32'(0));
        op8(8'h01, 8'h01, 8'h02, 1'b0); idle8();

        // start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        if8.a = 8'h80; if8.b = 8'h80; if8.start = 1'b1;
        acc0 = cyc + 1;
        for (int k = 0; k < 3; k++) q8.push_back('{sum: 8'h00, cout: 1'b1, acc: acc0 + 10 * k});
        while (cyc < acc0 + 20) @(negedge clk);
        if8.start = 1'b0;
        @(negedge clk);
        idle8();

        // WIDTH=2 instance, all operand pairs.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                op2(2'(a), 2'(b));

        repeat (4) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'(0));
        chk("q2_drained", 32'(q2.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder controller that time-shares one full-adder bit cell, built from two halfadder instances plus an OR, across all operand bits.
- Accepts operands with a start pulse, feeds one bit pair per clock LSB-first, and keeps the carry in a flip-flop.
- Returns sum and carry-out with a one-cycle done pulse.
- Sits between the lab's control/test logic and the halfadder datapath, trading area for latency.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
sum  output  WIDTH  registered result, a+b mod 2^WIDTH
cout  output  1  registered carry-out of the addition

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, any time):
  - state=IDLE; count, carry, operand and result shift registers = 0.
  - Outputs: busy=0, done=0, sum=0, cout=0.
  - Takes effect immediately, without waiting for a clock edge. Reset mid-RUN abandons the operation; no done is produced.
- State machine, three states; all outputs are registered:
  - IDLE: if start=1 at an edge, load shA=a, shB=b, clear carry=0, count=0, clear the result shift register, and go to RUN. Otherwise stay.
  - RUN: each edge:
    - Bit cell computes s=shA[0]^shB[0]^carry and c=(shA[0]&shB[0])|((shA[0]^shB[0])&carry).
    - carry<=c. Result register shifts right with s entering the MSB. shA and shB shift right. count<=count+1.
    - On the edge where count==WIDTH-1: go to DONE, load sum<=final result including the current bit, cout<=c, done<=1.
  - DONE: lasts one cycle. On the next edge done<=0 and go to IDLE. sum and cout keep their value.
- Latency: start is accepted at edge E0. Bits are processed at edges E0+1..E0+WIDTH. done is high for exactly the cycle after edge E0+WIDTH. The next start is accepted no earlier than edge E0+WIDTH+2.
- sum and cout change only on the completion edge (or reset). They are stable and valid from done until the next completion. Partial results are never visible.
- start in RUN or DONE is ignored, with no queuing. If start is held high continuously, a new operation is accepted on the first edge in IDLE.
- a and b are don't-care outside the accepting edge. Changing them during RUN has no effect.
- Arithmetic is unsigned and modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout. The signed overflow flag is not provided.
- Unreachable state encoding: recover to IDLE on the next edge with done=0.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encodings: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
  - default WIDTH constant.
- One sub-module, full_adder_bit, is natural: inputs x, y, cin; outputs s, co.
  - Composed of two halfadder instances, with co the OR of their carries.
  - Purely combinational; instantiated once.
- The FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
1. Reset asserted then released; a=8'h05, b=8'h03, start pulse -> busy=1 next cycle, done high exactly 8 cycles after the accepting edge, sum=8'h08, cout=0; outputs held after done falls.
2. a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1. Then a=8'h00, b=8'h00 -> sum=8'h00, cout=0.
3. Start pulses during RUN and in the DONE cycle, with a/b changed mid-RUN -> exactly one done; result matches the originally captured operands 8'h12+8'h34=8'h46.
4. rst_n pulled low asynchronously (between edges) at bit 4 of 8'hAA+8'h55 -> busy/done/sum/cout go to 0 immediately; no done follows; a fresh 8'h01+8'h01 then yields 8'h02.
5. start held high continuously with a=8'h80, b=8'h80 -> done pulses every 10 cycles (WIDTH+2); every result is sum=8'h00, cout=1.
6. WIDTH=2 build, exhaustive 16 operand pairs -> every sum/cout matches a+b; done 2 cycles after each accept.
